// File: rtl/md_pkg.sv
// md_pkg: encodings shared between the EX-stage issue logic and the MD unit.
// The MD unit decodes md_op with exactly these values.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;
    localparam logic [2:0] MD_MFHI  = 3'b110;
    localparam logic [2:0] MD_MFLO  = 3'b111;
    // Idle command shares the mflo code: the MD unit treats it as "no operation".
    localparam logic [2:0] MD_NOP   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WRITE = 2'b10,
        ST_WAIT  = 2'b11
    } md_state_e;

    function automatic logic md_is_arith(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic md_is_write(input logic [2:0] op);
        return (op[2:1] == 2'b10);
    endfunction

    function automatic logic md_is_read(input logic [2:0] op);
        return (op[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/md_issue.sv
// md_issue: EX-stage issue control for the multiply/divide unit. Decodes MD
// instructions, sequences start/HI-LO write commands, forwards HI/LO reads and watches md_busy.
module md_issue
    import md_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [2:0]  ex_op,
    input  logic        ex_md,
    input  logic        ex_flush,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        md_start,
    output logic [2:0]  md_op,
    output logic [31:0] md_data1,
    output logic [31:0] md_data2,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        md_timeout
);

    // The counter only needs to reach TIMEOUT+1; it saturates there.
    localparam int unsigned       WD_CW    = $clog2(TIMEOUT + 2);
    localparam logic [WD_CW-1:0]  WD_LIMIT = WD_CW'(TIMEOUT);
    localparam logic [WD_CW-1:0]  WD_MAX   = WD_CW'(TIMEOUT + 1);
    localparam logic [WD_CW-1:0]  WD_ONE   = WD_CW'(1);

    md_state_e          state_r;
    logic [2:0]         op_q_r;
    logic [31:0]        rs_q_r;
    logic [31:0]        rt_q_r;
    logic [WD_CW-1:0]   wd_cnt_r;
    logic               md_timeout_r;

    logic               stall_s;
    logic               accept_s;
    logic               rd_valid_s;
    logic [31:0]        rd_data_s;
    logic               md_start_s;
    logic [2:0]         md_op_s;
    logic [31:0]        md_data1_s;
    logic [31:0]        md_data2_s;

    // Hazard detection, instruction accept and HI/LO read forwarding
    always_comb begin
        stall_s    = 1'b0;
        accept_s   = 1'b0;
        rd_valid_s = 1'b0;
        rd_data_s  = 32'd0;
        if (ex_valid && ex_md && ((state_r != ST_IDLE) || md_busy)) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
        accept_s = ex_valid && ex_md && !ex_flush && !stall_s;
        if (accept_s && md_is_read(ex_op)) begin
            rd_valid_s = 1'b1;
            if (ex_op == MD_MFHI) begin
                rd_data_s = md_hi;
            end else begin
                rd_data_s = md_lo;
            end
        end else begin
            rd_valid_s = 1'b0;
            rd_data_s  = 32'd0;
        end
    end

    // Issue sequencer and capture of the accepted instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            op_q_r  <= 3'b000;
            rs_q_r  <= 32'd0;
            rt_q_r  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && md_is_arith(ex_op)) begin
                        state_r <= ST_ISSUE;
                        op_q_r  <= ex_op;
                        rs_q_r  <= rs_val;
                        rt_q_r  <= rt_val;
                    end else if (accept_s && md_is_write(ex_op)) begin
                        state_r <= ST_WRITE;
                        op_q_r  <= ex_op;
                        rs_q_r  <= rs_val;
                        rt_q_r  <= rt_val;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT;
                end
                ST_WRITE: begin
                    state_r <= ST_IDLE;
                end
                ST_WAIT: begin
                    if (md_busy) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Commands to the MD unit depend only on flops; HI/LO write codes leave only in WRITE
    always_comb begin
        md_start_s = 1'b0;
        md_op_s    = MD_NOP;
        md_data1_s = 32'd0;
        md_data2_s = 32'd0;
        case (state_r)
            ST_ISSUE: begin
                md_start_s = 1'b1;
                md_op_s    = op_q_r;
                md_data1_s = rs_q_r;
                md_data2_s = rt_q_r;
            end
            ST_WRITE: begin
                md_start_s = 1'b0;
                md_op_s    = op_q_r;
                md_data1_s = rs_q_r;
                md_data2_s = 32'd0;
            end
            default: begin
                md_start_s = 1'b0;
                md_op_s    = MD_NOP;
                md_data1_s = 32'd0;
                md_data2_s = 32'd0;
            end
        endcase
    end

    // Watchdog on consecutive md_busy cycles; the error flag is sticky until reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_r     <= {WD_CW{1'b0}};
            md_timeout_r <= 1'b0;
        end else if (md_busy) begin
            if (wd_cnt_r < WD_MAX) begin
                wd_cnt_r <= wd_cnt_r + WD_ONE;
            end else begin
                wd_cnt_r <= wd_cnt_r;
            end
            if (wd_cnt_r >= WD_LIMIT) begin
                md_timeout_r <= 1'b1;
            end else begin
                md_timeout_r <= md_timeout_r;
            end
        end else begin
            wd_cnt_r     <= {WD_CW{1'b0}};
            md_timeout_r <= md_timeout_r;
        end
    end

    assign stall      = stall_s;
    assign rd_valid   = rd_valid_s;
    assign rd_data    = rd_data_s;
    assign md_start   = md_start_s;
    assign md_op      = md_op_s;
    assign md_data1   = md_data1_s;
    assign md_data2   = md_data2_s;
    assign md_timeout = md_timeout_r;

endmodule

// File: tb/tb_md_issue.sv
// tb_md_issue: random and directed stimulus for md_issue, with a small MD unit
// and a cycle-level reference model of the issue rules checked on every falling edge.
module tb_md_issue;
    import md_pkg::*;

    localparam int unsigned TIMEOUT = 15;

    logic        clk;
    logic        reset;
    logic        ex_valid, ex_md, ex_flush;
    logic [2:0]  ex_op;
    logic [31:0] rs_val, rt_val;
    logic        md_busy;
    logic [31:0] md_hi, md_lo;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_data1, md_data2;
    logic        stall;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        md_timeout;

    int checks = 0;
    int errors = 0;

    md_issue #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_md(ex_md), .ex_flush(ex_flush),
        .rs_val(rs_val), .rt_val(rt_val),
        .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo),
        .md_start(md_start), .md_op(md_op), .md_data1(md_data1), .md_data2(md_data2),
        .stall(stall), .rd_data(rd_data), .rd_valid(rd_valid), .md_timeout(md_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // HI/LO result of an MD operation; prev is returned for non-arithmetic ops or divide by zero
    function automatic logic [63:0] md_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] prev);
        logic signed [31:0] sa, sb;
        logic signed [63:0] sp;
        sa = a;
        sb = b;
        case (op)
            MD_MULT:  begin sp = 64'(sa) * 64'(sb); return sp; end
            MD_MULTU: return {32'd0, a} * {32'd0, b};
            MD_DIV:   if (b == 32'd0) return prev; else return {32'(sa % sb), 32'(sa / sb)};
            MD_DIVU:  if (b == 32'd0) return prev; else return {a % b, a / b};
            default:  return prev;
        endcase
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural MD unit: latency chosen by the stimulus, optional forced busy
    int unsigned env_lat;
    logic        force_busy;
    int unsigned busy_left;
    logic [31:0] unit_hi, unit_lo;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_left <= 0;
            unit_hi   <= 32'd0;
            unit_lo   <= 32'd0;
        end else if (md_start) begin
            busy_left <= env_lat;
            {unit_hi, unit_lo} <= md_result(md_op, md_data1, md_data2, {unit_hi, unit_lo});
        end else begin
            if (busy_left != 0) busy_left <= busy_left - 1;
            if (md_op == MD_MTHI) unit_hi <= md_data1;
            else if (md_op == MD_MTLO) unit_lo <= md_data1;
        end
    end

    assign md_busy = (busy_left != 0) || force_busy;
    assign md_hi   = unit_hi;
    assign md_lo   = unit_lo;

    // Reference model: m_cmd says what the command port must show this cycle
    // (0 nothing, 1 start pulse, 2 HI/LO write); m_wait marks an op still owned by the unit.
    int          m_cmd;
    logic        m_wait;
    logic [2:0]  m_op;
    logic [31:0] m_d1, m_d2;
    logic [31:0] arch_hi, arch_lo;
    int unsigned m_run;
    logic        m_timeout;

    always @(negedge clk) begin
        logic        e_stall, e_acc, e_rdv;
        logic [31:0] e_rdd;
        logic [63:0] res;
        if (!reset) begin
            chk1("rst_md_start", md_start, 1'b0);
            chk32("rst_md_op", 32'(md_op), 32'(MD_NOP));
            chk32("rst_md_data1", md_data1, 32'd0);
            chk32("rst_md_data2", md_data2, 32'd0);
            chk1("rst_rd_valid", rd_valid, 1'b0);
            chk32("rst_rd_data", rd_data, 32'd0);
            chk1("rst_md_timeout", md_timeout, 1'b0);
            chk1("rst_stall", stall, ex_valid & ex_md & md_busy);
            m_cmd <= 0; m_wait <= 1'b0; m_op <= MD_NOP; m_d1 <= 32'd0; m_d2 <= 32'd0;
            arch_hi <= 32'd0; arch_lo <= 32'd0; m_run <= 0; m_timeout <= 1'b0;
        end else begin
            e_stall = ex_valid && ex_md && (m_cmd != 0 || m_wait || md_busy);
            e_acc   = ex_valid && ex_md && !ex_flush && !e_stall;
            e_rdv   = e_acc && (ex_op == MD_MFHI || ex_op == MD_MFLO);
            e_rdd   = !e_rdv ? 32'd0 : (ex_op == MD_MFHI ? arch_hi : arch_lo);
            chk1("stall", stall, e_stall);
            chk1("rd_valid", rd_valid, e_rdv);
            chk32("rd_data", rd_data, e_rdd);
            chk1("md_start", md_start, m_cmd == 1);
            chk32("md_op", 32'(md_op), 32'(m_op));
            chk1("md_timeout", md_timeout, m_timeout);
            if (m_cmd != 0) chk32("md_data1", md_data1, m_d1);
            if (m_cmd == 1 || (m_cmd == 0 && !m_wait)) chk32("md_data2", md_data2, m_d2);
            if (m_cmd == 0 && !m_wait) chk32("idle_data1", md_data1, 32'd0);

            m_wait <= (m_cmd == 1) || (m_wait && md_busy);
            m_run  <= md_busy ? m_run + 1 : 0;
            if (md_busy && (m_run + 1 > TIMEOUT)) m_timeout <= 1'b1;
            if (e_acc && ex_op <= MD_DIVU) begin
                m_cmd <= 1; m_op <= ex_op; m_d1 <= rs_val; m_d2 <= rt_val;
                res = md_result(ex_op, rs_val, rt_val, {arch_hi, arch_lo});
                arch_hi <= res[63:32];
                arch_lo <= res[31:0];
            end else if (e_acc && (ex_op == MD_MTHI || ex_op == MD_MTLO)) begin
                m_cmd <= 2; m_op <= ex_op; m_d1 <= rs_val; m_d2 <= 32'd0;
                if (ex_op == MD_MTHI) arch_hi <= rs_val; else arch_lo <= rs_val;
            end else begin
                m_cmd <= 0; m_op <= MD_NOP; m_d1 <= 32'd0; m_d2 <= 32'd0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic md, input logic [2:0] op, input logic fl,
                         input logic [31:0] a, input logic [31:0] b);
        ex_valid = v; ex_md = md; ex_op = op; ex_flush = fl; rs_val = a; rt_val = b;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int          nb;
        logic        seen;
        logic [2:0]  op;
        logic [31:0] a, b;
        reset = 1'b0; force_busy = 1'b0; env_lat = 4;
        drive(1'b0, 1'b0, MD_NOP, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk32("reset_md_op", 32'(md_op), 32'h7);
        chk1("reset_md_start", md_start, 1'b0);
        reset = 1'b1;

        // mult -2 * 3, then read LO and HI
        drive(1'b1, 1'b1, MD_MULT, 1'b0, 32'hFFFFFFFE, 32'd3);
        cyc();
        drive(1'b0, 1'b0, MD_NOP, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk1("mult_start", md_start, 1'b1);
        chk32("mult_op", 32'(md_op), 32'h0);
        chk32("mult_data1", md_data1, 32'hFFFFFFFE);
        chk32("mult_data2", md_data2, 32'd3);
        cyc();
        @(negedge clk);
        chk1("mult_start_one_cycle", md_start, 1'b0);
        chk32("mult_wait_op", 32'(md_op), 32'h7);
        repeat (8) cyc();
        drive(1'b1, 1'b1, MD_MFLO, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk1("mflo_valid", rd_valid, 1'b1);
        chk32("mflo_data", rd_data, 32'hFFFFFFFA);
        cyc();
        drive(1'b1, 1'b1, MD_MFHI, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk32("mfhi_data", rd_data, 32'hFFFFFFFF);
        cyc();

        // div 7/2 with 10 busy cycles, mfhi waiting behind it
        env_lat = 10;
        drive(1'b1, 1'b1, MD_DIV, 1'b0, 32'd7, 32'd2);
        cyc();
        drive(1'b1, 1'b1, MD_MFHI, 1'b0, 32'd0, 32'd0);
        seen = 1'b0; nb = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (rd_valid) seen = 1'b1;
            else if (md_busy) begin
                nb++;
                chk1("div_busy_stall", stall, 1'b1);
            end
            if (!seen) cyc();
        end
        chk1("div_mfhi_seen", seen, 1'b1);
        chk32("div_busy_cycles", nb, 32'd10);
        if (seen) chk32("div_mfhi_data", rd_data, 32'd1);
        cyc();

        // mthi then mfhi
        drive(1'b1, 1'b1, MD_MTHI, 1'b0, 32'h12345678, 32'd0);
        cyc();
        drive(1'b0, 1'b0, MD_NOP, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk32("mthi_op", 32'(md_op), 32'h4);
        chk32("mthi_data1", md_data1, 32'h12345678);
        chk1("mthi_no_start", md_start, 1'b0);
        cyc();
        @(negedge clk);
        chk32("mthi_after_op", 32'(md_op), 32'h7);
        cyc();
        drive(1'b1, 1'b1, MD_MFHI, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk32("mthi_readback", rd_data, 32'h12345678);
        #1;
        chk32("model_arch_hi", arch_hi, 32'h12345678);
        cyc();

        // flushed multu is dropped; non-MD instruction does not stall during WAIT
        drive(1'b1, 1'b1, MD_MULTU, 1'b1, 32'd9, 32'd9);
        cyc();
        drive(1'b0, 1'b0, MD_NOP, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk1("flush_no_start", md_start, 1'b0);
        env_lat = 6;
        cyc();
        drive(1'b1, 1'b1, MD_MULT, 1'b0, 32'd5, 32'd6);
        cyc();
        drive(1'b1, 1'b0, 3'b010, 1'b0, 32'd1, 32'd2);
        cyc();
        @(negedge clk);
        chk1("addu_no_stall", stall, 1'b0);
        cyc();
        drive(1'b0, 1'b0, MD_NOP, 1'b0, 32'd0, 32'd0);
        repeat (10) cyc();

        // 20 busy cycles: watchdog fires after the 16th, then reset mid-WAIT
        env_lat = 20;
        drive(1'b1, 1'b1, MD_MULTU, 1'b0, 32'd3, 32'd4);
        cyc();
        drive(1'b0, 1'b0, MD_NOP, 1'b0, 32'd0, 32'd0);
        nb = 0;
        for (int i = 0; i < 40 && nb < 18; i++) begin
            @(negedge clk);
            if (md_busy) nb++;
            if (md_busy && nb == 16) chk1("wd_not_yet", md_timeout, 1'b0);
            if (md_busy && nb >= 17) chk1("wd_set", md_timeout, 1'b1);
            if (nb < 18) cyc();
        end
        chk32("wd_busy_run", nb, 32'd18);
        cyc();
        reset = 1'b0;
        #1;
        chk1("rst_mid_wait_timeout", md_timeout, 1'b0);
        chk32("rst_mid_wait_op", 32'(md_op), 32'h7);
        chk1("rst_mid_wait_start", md_start, 1'b0);
        chk1("rst_mid_wait_stall", stall, 1'b0);
        cyc();
        cyc();
        reset = 1'b1;

        // randomized traffic with one reset in the middle
        for (int i = 0; i < 800; i++) begin
            cyc();
            if (i == 400) reset = 1'b0;
            if (i == 402) reset = 1'b1;
            env_lat    = ($urandom_range(0, 49) == 0) ? 18 : $urandom_range(1, 8);
            force_busy = ($urandom_range(0, 24) == 0);
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ((op == MD_DIV || op == MD_DIVU) && (b == 32'd0 || b == 32'hFFFFFFFF)) b = 32'd7;
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, op,
                  $urandom_range(0, 9) == 0, a, b);
        end
        cyc();
        force_busy = 1'b0;
        drive(1'b0, 1'b0, MD_NOP, 1'b0, 32'd0, 32'd0);
        repeat (30) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
